// File: rtl/ps2_dev_tx.sv
// PS/2 device-side transmitter: serialises bytes into 11-bit frames on the PS/2
// clock/data lines, deferring while the host inhibits and retrying after an abort.
module ps2_dev_tx #(
    parameter int CLK_HALF = 2500,
    parameter int IDLE_GAP = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic       ps2_clk_in,
    output logic       ps2_clk_out,
    output logic       ps2_data_out,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_abort
);

    localparam int TMAX = (CLK_HALF > IDLE_GAP) ? CLK_HALF : IDLE_GAP;
    localparam int TW   = $clog2(TMAX + 1);
    // After our own clock release the synchroniser still shows the low we drove
    // for two cycles, so inhibit is only trusted from this timer value on.
    localparam int SYNC_LAT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_INH,
        S_GAP
    } state_t;

    state_t          state, state_n;
    logic [10:0]     frame, frame_n;
    logic [3:0]      bit_idx, bit_idx_n;
    logic [3:0]      next_idx;
    logic [TW-1:0]   timer, timer_n;
    logic [1:0]      sync;
    logic            inh_n;
    logic            host_inhibit;
    logic            clk_out_q, clk_out_n;
    logic            data_out_q, data_out_n;
    logic            done_q, done_n;
    logic            abort_q, abort_n;

    assign inh_n        = sync[1];
    assign host_inhibit = ~inh_n & clk_out_q;
    assign data_ready   = (state == S_IDLE) & inh_n & ~rst;
    assign busy         = (state != S_IDLE);
    assign ps2_clk_out  = clk_out_q;
    assign ps2_data_out = data_out_q;
    assign tx_done      = done_q;
    assign tx_abort     = abort_q;
    assign next_idx     = bit_idx + 4'd1;

    // NOTE: state is registered with non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            frame      <= '0;
            bit_idx    <= '0;
            timer      <= '0;
            sync       <= 2'b11;
            clk_out_q  <= 1'b1;
            data_out_q <= 1'b1;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state      <= state_n;
            frame      <= frame_n;
            bit_idx    <= bit_idx_n;
            timer      <= timer_n;
            sync       <= {sync[0], ps2_clk_in};
            clk_out_q  <= clk_out_n;
            data_out_q <= data_out_n;
            done_q     <= done_n;
            abort_q    <= abort_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_n    = state;
        frame_n    = frame;
        bit_idx_n  = bit_idx;
        timer_n    = timer;
        clk_out_n  = 1'b1;
        data_out_n = 1'b1;
        done_n     = 1'b0;
        abort_n    = 1'b0;

        case (state)
            S_IDLE: begin
                if (data_valid && data_ready) begin
                    frame_n    = {1'b1, ~^data_in, data_in, 1'b0};
                    bit_idx_n  = 4'd0;
                    timer_n    = '0;
                    state_n    = S_HIGH;
                    data_out_n = 1'b0;
                end
            end

            S_HIGH: begin
                data_out_n = frame[bit_idx];
                if (host_inhibit && timer >= TW'(SYNC_LAT) && bit_idx <= 4'd9) begin
                    state_n    = S_INH;
                    timer_n    = '0;
                    abort_n    = 1'b1;
                    data_out_n = 1'b1;
                end else if (timer == TW'(CLK_HALF - 1)) begin
                    state_n   = S_LOW;
                    timer_n   = '0;
                    clk_out_n = 1'b0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end

            S_LOW: begin
                clk_out_n  = 1'b0;
                data_out_n = frame[bit_idx];
                if (timer == TW'(CLK_HALF - 1)) begin
                    timer_n   = '0;
                    clk_out_n = 1'b1;
                    if (bit_idx == 4'd10) begin
                        state_n    = S_GAP;
                        done_n     = 1'b1;
                        data_out_n = 1'b1;
                    end else begin
                        state_n    = S_HIGH;
                        bit_idx_n  = next_idx;
                        data_out_n = frame[next_idx];
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end

            S_INH: begin
                // Retry needs IDLE_GAP consecutive released cycles.
                if (!inh_n) begin
                    timer_n = '0;
                end else if (timer == TW'(IDLE_GAP - 1)) begin
                    state_n    = S_HIGH;
                    bit_idx_n  = 4'd0;
                    timer_n    = '0;
                    data_out_n = frame[0];
                end else begin
                    timer_n = timer + 1'b1;
                end
            end

            S_GAP: begin
                if (timer == TW'(IDLE_GAP - 1)) begin
                    state_n = S_IDLE;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end

            default: begin
                state_n = S_IDLE;
                timer_n = '0;
            end
        endcase
    end

endmodule

// File: doc/ps2_dev_tx.md
Name: ps2_dev_tx

Overview:
PS/2 device-side transmitter. It serialises bytes into standard 11-bit PS/2 frames and drives the PS/2 clock and data lines toward the host. It is the keyboard end of the link whose host end our top-level decodes. It serves as a synthesizable keyboard emulator for board loopback and as the stimulus source in the top-level bench. It honours host inhibit by deferring or aborting and retrying.

Parameters:
CLK_HALF, 2500, system-clock cycles per PS/2 clock half-period (50 MHz gives 10 kHz); must be >= 2.
IDLE_GAP, 5000, minimum system-clock cycles with both lines released between frames.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
data_in  in  8  byte to transmit
data_valid  in  1  data_in valid
data_ready  out  1  block can accept a byte this cycle
ps2_clk_in  in  1  sensed PS/2 clock line (wired-AND of host and device)
ps2_clk_out  out  1  device clock drive; 1 = released/high, 0 = pull low
ps2_data_out  out  1  device data drive; 1 = released/high, 0 = pull low
busy  out  1  frame in progress or inter-frame gap
tx_done  out  1  one-cycle pulse after a frame's stop-bit low phase ends
tx_abort  out  1  one-cycle pulse when a frame is aborted by host inhibit

Behaviour:
- Reset (rst high at a clock edge):
  - state IDLE; ps2_clk_out=1, ps2_data_out=1; busy=0, tx_done=0, tx_abort=0.
  - Synchroniser flops = 1; timer and bit index = 0.
  - data_ready is forced 0 while rst=1.
  - Reset mid-frame releases both lines on the next edge; the pending byte is discarded.
- Inhibit sense:
  - ps2_clk_in passes through a 2-flop synchroniser to give inh_n.
  - Host inhibit means inh_n=0 while ps2_clk_out=1.
- data_ready = (state==IDLE) & inh_n & ~rst. This is combinational from registered state.
- Accept: data_valid & data_ready at an edge.
  - Latch data_in and compute odd parity: parity = ~^data_in.
  - Build frame[10:0] = {1, parity, data_in, 0}. Bit 0 (the start bit) is sent first; data is sent LSB first.
  - Go to HIGH with bit_idx=0, timer=0. busy rises on the same edge.
- States:
  - IDLE: both lines released.
  - HIGH: ps2_data_out = frame[bit_idx], set on entry. ps2_clk_out=1 for CLK_HALF cycles, then go to LOW.
    - If inhibit is seen in HIGH while bit_idx <= 9: abort. Release both lines, pulse tx_abort, keep the latched byte, go to INH.
    - If inhibit is seen with bit_idx == 10: ignore it and finish the frame.
  - LOW: ps2_clk_out=0 for CLK_HALF cycles; data is held.
    - When bit_idx < 10: go to HIGH with bit_idx+1.
    - When bit_idx == 10: release both lines, pulse tx_done, go to GAP.
  - INH: lines released. Wait until inh_n=1 for IDLE_GAP consecutive cycles, then retransmit the latched byte from the start bit (to HIGH). busy stays 1.
  - GAP: lines released for IDLE_GAP cycles, then go to IDLE. busy drops on the IDLE entry edge.
- Timing:
  - One bit cell = 2*CLK_HALF cycles; one frame = 22*CLK_HALF cycles.
  - Data changes only at the start of a high phase, so the host sees data stable for CLK_HALF cycles before the falling edge.
- Inhibit already present in IDLE: data_ready stays 0; the byte is not accepted until inh_n=1.
- data_valid while busy is ignored; no queueing.
- data_valid held high continuously: the next byte is accepted on the first IDLE cycle. Minimum spacing between frame starts is 22*CLK_HALF + IDLE_GAP + 1 cycles.
- The LOW phase does not check ps2_clk_in, because the device's own low drive masks the line.

Test Plan:
(CLK_HALF=4, IDLE_GAP=8 for all scenarios.)
1. Reset, then data_in=0x1C with valid for one cycle.
   - Data, sampled at each ps2_clk_out falling edge, must be 0,0,0,1,1,1,0,0,0,0,1 (parity 0).
   - The frame lasts 88 cycles; tx_done pulses once; data_ready returns 8 cycles after tx_done.
2. Send 0xF0, then 0x00, with data_valid held high.
   - Parities must be 1 and 1.
   - The second start bit begins exactly 97 cycles after the first accept.
   - There must be no clk_out activity during the gap.
3. Hold ps2_clk_in=0 from reset, with valid=1 and data 0x5A.
   - data_ready must stay 0 and the lines must stay released.
   - Release ps2_clk_in: the byte is accepted 3 cycles later (synchroniser plus ready).
4. Drive ps2_clk_in=0 during the HIGH phase of bit 4.
   - tx_abort pulses and both lines are released.
   - After ps2_clk_in returns high for 8 cycles, the full frame for the same byte is retransmitted and tx_done pulses once.
5. Inhibit during the stop-bit HIGH phase: the frame completes, tx_done pulses, and tx_abort stays 0.
6. Assert rst during bit 6.
   - Next edge: clk_out=1, data_out=1, busy=0.
   - After rst is released, data_ready=1 and no residual frame is sent.
